// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready on both sides.
// Optional AES_KEY_LATCH_EN: capture the round-key schedule on the accept edge.
module aes_encrypt_iter #(
    parameter int NR   = 10,
    parameter int RC_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  plaintext,
    input  logic [1407:0] round_keys,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  ciphertext
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]      fsm;
    logic [RC_W-1:0] round;
    logic [127:0]    state;
    logic [127:0]    rk;
    logic [127:0]    sb;
    logic [127:0]    sr;
    logic [127:0]    mc;
    logic [127:0]    next_state;
    logic            last_round;
    logic            accept;

    // Byte b sits at MSB index 2047 - 8*b, which is {~b, 3'b111}
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    assign in_ready   = (fsm == IDLE) & ~rst;
    assign out_valid  = (fsm == DONE);
    assign ciphertext = state;
    assign accept     = in_valid & in_ready;
    assign last_round = (round == RC_W'(NR));

`ifdef AES_KEY_LATCH_EN
    logic [1407:0] key_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            key_q <= round_keys;
        end
    end

    assign rk = key_q[{round, 7'b0} +: 128];
`else
    assign rk = round_keys[{round, 7'b0} +: 128];
`endif

    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
        end
        // Row r of column c takes the byte from column (c + r) mod 4
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        end
        next_state = (last_round ? sr : mc) ^ rk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm   <= IDLE;
            round <= '0;
            state <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state <= plaintext ^ round_keys[127:0];
                        round <= RC_W'(1);
                        fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    state <= next_state;
                    if (last_round) begin
                        fsm <= DONE;
                    end else begin
                        round <= round + RC_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm   <= IDLE;
                        round <= '0;
                    end
                end
                default: begin
                    fsm   <= IDLE;
                    round <= '0;
                end
            endcase
        end
    end

endmodule
